issue_queue_unit: RTL
=====================

Name: issue_queue_unit

Overview:
- Parametrised successor to the single-shot issue stage.
- Buffers decoded instructions in a DEPTH-entry FIFO and reads register operands at issue time.
- Tracks pending register writes in a per-register scoreboard and stalls on RAW hazards, with same-cycle writeback forwarding.
- Drives ALU, PC_ALU and LSU operands through a registered valid/ready output stage.

Parameters:
- DATA_W, 32, operand/PC/immediate width.
- DEPTH, 4, FIFO entries (power of two, >=2).
- NUM_REGS, 32, architectural registers; register 0 hardwired zero.
- ALU_OP_W, 4, ALU operator encoding width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous active-low reset, sampled on clk_i rising edge.
- flush_i  in  1  discard FIFO contents and output stage.
- in_valid_i  in  1  decode packet valid.
- in_ready_o  out  1  FIFO not full.
- in_pc_i  in  DATA_W  instruction PC.
- in_imm_i  in  DATA_W  immediate, already selected and extended by decode.
- in_rs1_i / in_rs2_i / in_rd_i  in  log2(NUM_REGS) each  register addresses.
- in_op_a_sel_i  in  2  0=REG, 1=ZERO, 2=CURRPC.
- in_op_b_sel_i  in  1  0=REG, 1=IMM.
- in_alu_req_i, in_pc_req_i, in_data_req_i, in_data_we_i  in  1 each  unit requests.
- in_pc_op_i  in  2  0=JAL, 1=JALR, 2=BRANCH.
- in_alu_op_i  in  ALU_OP_W  ALU operator.
- rf_raddr_a_o / rf_raddr_b_o  out  log2(NUM_REGS)  equal to head rs1/rs2, combinational.
- rf_rdata_a_i / rf_rdata_b_i  in  DATA_W  combinational RF read data.
- wb_valid_i  in  1  writeback strobe.
- wb_waddr_i  in  log2(NUM_REGS)  writeback destination.
- wb_wdata_i  in  DATA_W  writeback data.
- out_valid_o  out  1  issued packet valid.
- out_ready_i  in  1  execute accepts.
- operand_alu_a_o, operand_alu_b_o, operand_pc_alu_a_o, operand_pc_alu_b_o, lsu_wdata_o  out  DATA_W each  issued operands.
- operateur_alu_o  out  ALU_OP_W  ALU operator.
- req_alu_o, data_req_o, data_we_o, branch_bool_o, rf_soursel_o, req_rf_w_o  out  1 each  control.
- rf_waddr_o  out  log2(NUM_REGS)  destination register.

Behaviour:
- Reset: FIFO empty; scoreboard all clear; every output 0 except in_ready_o=1; operateur_alu_o=0 (ADD).
- Push on in_valid_i && in_ready_o. No push when full.
- Issue when all of the following hold; the head pops and the output registers load on the next edge (1-cycle latency from head to out_valid_o):
  - FIFO not empty.
  - No hazard.
  - !out_valid_o || out_ready_i.
- Output registers hold stable while out_valid_o && !out_ready_i. out_valid_o clears on handshake with no new issue.
- Simultaneous push and pop when full: push is refused that cycle, because in_ready_o is computed from the registered count.
- Source register usage:
  - rs1 used when (alu_req && op_a=REG) || data_req || pc_op=JALR || pc_op=BRANCH.
  - rs2 used when (alu_req && op_b=REG) || (data_req && data_we) || pc_op=BRANCH.
- Hazard: a used rs != 0 has its busy bit set and is not matched by wb_valid_i && wb_waddr_i==rs that cycle. On a match, wb_wdata_i is forwarded in place of rf_rdata.
- Register 0 reads 0 and is never busy.
- Operand selection:
  - ALU a: REG → rs1 value, ZERO → 0, CURRPC → pc.
  - ALU b: REG → rs2 value, IMM → imm.
  - ALU operands and operator are zero/ADD when alu_req=0.
- PC_ALU:
  - a = rs1 value for JALR, otherwise pc.
  - b = imm.
  - branch_bool_o = pc_req && pc_op=BRANCH.
  - pc_req=0 gives a=pc, b=imm, branch_bool=0.
- LSU:
  - data_req_o and data_we_o pass through.
  - lsu_wdata_o = rs2 value for stores, otherwise 0.
  - rf_soursel_o = data_req && !data_we.
- req_rf_w_o = alu_req || (data_req && !data_we). rf_waddr_o = rd.
- Scoreboard:
  - On issue with req_rf_w && rd != 0, set busy[rd].
  - On wb_valid_i, clear busy[wb_waddr_i].
  - If set and clear target the same register in the same cycle, set wins.
- flush_i: empties the FIFO and clears out_valid_o next edge. Scoreboard is untouched, since outstanding writebacks still retire. Issue is suppressed in the flush cycle. Flush takes priority over push.
- Reset mid-operation discards everything regardless of handshake state.

Test Plan:
- Push ADD x3=x1+x2 (x1=5, x2=7), out_ready_i=1 → next cycle out_valid_o=1, operands 5/7, req_rf_w_o=1, rf_waddr_o=3, busy[3]=1.
- Load to x4, then ADD x5=x4+x0 with no writeback → ADD stalls at head. wb_valid_i with x4=0x99 → ADD issues that cycle with operand_alu_a_o=0x99 (forwarded).
- Hold out_ready_i=0 and push 5 packets with DEPTH=4 → one in output stage, FIFO full, in_ready_o=0, outputs stable. Release → drains in order.
- BRANCH with pc=0x100, imm=0x20 → operand_pc_alu_a_o=0x100, operand_pc_alu_b_o=0x20, branch_bool_o=1, req_rf_w_o=0.
- Store rs2=x6 (0xABCD) → data_req_o=1, data_we_o=1, lsu_wdata_o=0xABCD, rf_soursel_o=0, req_rf_w_o=0.
- flush_i with 3 queued entries, and separately rst_ni=0 mid-stall → FIFO empty, out_valid_o=0 next edge. Busy bits retained after flush, cleared after reset.

Source files
------------

// File: rtl/issue_queue_unit.sv
// issue_queue_unit: FIFO-buffered issue stage with scoreboard RAW stall,
// writeback forwarding and a registered valid/ready operand stage.
module issue_queue_unit #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = 32,
  parameter int ALU_OP_W = 4,
  localparam int RW = $clog2(NUM_REGS),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_W-1:0]   in_pc_i,
  input  logic [DATA_W-1:0]   in_imm_i,
  input  logic [RW-1:0]       in_rs1_i,
  input  logic [RW-1:0]       in_rs2_i,
  input  logic [RW-1:0]       in_rd_i,
  input  logic [1:0]          in_op_a_sel_i,
  input  logic                in_op_b_sel_i,
  input  logic                in_alu_req_i,
  input  logic                in_pc_req_i,
  input  logic                in_data_req_i,
  input  logic                in_data_we_i,
  input  logic [1:0]          in_pc_op_i,
  input  logic [ALU_OP_W-1:0] in_alu_op_i,
  output logic [RW-1:0]       rf_raddr_a_o,
  output logic [RW-1:0]       rf_raddr_b_o,
  input  logic [DATA_W-1:0]   rf_rdata_a_i,
  input  logic [DATA_W-1:0]   rf_rdata_b_i,
  input  logic                wb_valid_i,
  input  logic [RW-1:0]       wb_waddr_i,
  input  logic [DATA_W-1:0]   wb_wdata_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   operand_alu_a_o,
  output logic [DATA_W-1:0]   operand_alu_b_o,
  output logic [DATA_W-1:0]   operand_pc_alu_a_o,
  output logic [DATA_W-1:0]   operand_pc_alu_b_o,
  output logic [DATA_W-1:0]   lsu_wdata_o,
  output logic [ALU_OP_W-1:0] operateur_alu_o,
  output logic                req_alu_o,
  output logic                data_req_o,
  output logic                data_we_o,
  output logic                branch_bool_o,
  output logic                rf_soursel_o,
  output logic                req_rf_w_o,
  output logic [RW-1:0]       rf_waddr_o
);
  typedef struct packed {
    logic [DATA_W-1:0]   pc, imm;
    logic [RW-1:0]       rs1, rs2, rd;
    logic [1:0]          sa;
    logic                sb, alu, pcr, dr, dw;
    logic [1:0]          pco;
    logic [ALU_OP_W-1:0] aop;
  } pkt_t;
  typedef struct packed {
    logic                vld;
    logic [DATA_W-1:0]   alu_a, alu_b, pc_a, pc_b, lsu;
    logic [ALU_OP_W-1:0] aop;
    logic                alu, dr, dw, br, src, rfw;
    logic [RW-1:0]       wa;
  } out_t;
  pkt_t                r_mem [DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [AW:0]         r_cnt;
  logic [NUM_REGS-1:0] r_busy, w_busy;
  out_t                r_out, w_out;
  pkt_t                w_in, w_hd;
  logic                w_empty, w_use1, w_use2, w_fw1, w_fw2, w_haz, w_issue, w_push;
  logic [DATA_W-1:0]   w_v1, w_v2;
  assign w_in = '{pc: in_pc_i, imm: in_imm_i, rs1: in_rs1_i, rs2: in_rs2_i, rd: in_rd_i,
                  sa: in_op_a_sel_i, sb: in_op_b_sel_i, alu: in_alu_req_i, pcr: in_pc_req_i,
                  dr: in_data_req_i, dw: in_data_we_i, pco: in_pc_op_i, aop: in_alu_op_i};
  assign w_hd       = r_mem[r_rp];
  assign w_empty    = r_cnt == '0;
  assign in_ready_o = r_cnt != (AW+1)'(DEPTH);
  assign rf_raddr_a_o = w_empty ? '0 : w_hd.rs1;
  assign rf_raddr_b_o = w_empty ? '0 : w_hd.rs2;
  assign w_use1 = (w_hd.alu && w_hd.sa == 2'd0) || w_hd.dr || w_hd.pco == 2'd1 || w_hd.pco == 2'd2;
  assign w_use2 = (w_hd.alu && !w_hd.sb) || (w_hd.dr && w_hd.dw) || w_hd.pco == 2'd2;
  assign w_fw1  = wb_valid_i && wb_waddr_i == w_hd.rs1;
  assign w_fw2  = wb_valid_i && wb_waddr_i == w_hd.rs2;
  assign w_haz  = (w_use1 && w_hd.rs1 != '0 && r_busy[w_hd.rs1] && !w_fw1) ||
                  (w_use2 && w_hd.rs2 != '0 && r_busy[w_hd.rs2] && !w_fw2);
  assign w_v1 = w_hd.rs1 == '0 ? '0 : w_fw1 ? wb_wdata_i : rf_rdata_a_i;
  assign w_v2 = w_hd.rs2 == '0 ? '0 : w_fw2 ? wb_wdata_i : rf_rdata_b_i;
  assign w_issue = !w_empty && !w_haz && (!r_out.vld || out_ready_i) && !flush_i;
  assign w_push  = in_valid_i && in_ready_o && !flush_i;
  always_comb begin
    w_out.vld   = 1'b1;
    w_out.alu_a = !w_hd.alu ? '0 : w_hd.sa == 2'd0 ? w_v1 : w_hd.sa == 2'd2 ? w_hd.pc : '0;
    w_out.alu_b = !w_hd.alu ? '0 : w_hd.sb ? w_hd.imm : w_v2;
    w_out.pc_a  = (w_hd.pcr && w_hd.pco == 2'd1) ? w_v1 : w_hd.pc;
    w_out.pc_b  = w_hd.imm;
    w_out.lsu   = (w_hd.dr && w_hd.dw) ? w_v2 : '0;
    w_out.aop   = w_hd.alu ? w_hd.aop : '0;
    w_out.alu   = w_hd.alu;
    w_out.dr    = w_hd.dr;
    w_out.dw    = w_hd.dw;
    w_out.br    = w_hd.pcr && w_hd.pco == 2'd2;
    w_out.src   = w_hd.dr && !w_hd.dw;
    w_out.rfw   = w_hd.alu || (w_hd.dr && !w_hd.dw);
    w_out.wa    = w_hd.rd;
  end
  // a new reservation overrides a same-cycle writeback to that register
  always_comb begin
    w_busy = r_busy;
    if (wb_valid_i) w_busy[wb_waddr_i] = 1'b0;
    if (w_issue && w_out.rfw && w_hd.rd != '0) w_busy[w_hd.rd] = 1'b1;
    w_busy[0] = 1'b0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_busy <= '0;
      r_out  <= '0;
    end else begin
      r_busy <= w_busy;
      if (flush_i) begin
        r_wp      <= '0;
        r_rp      <= '0;
        r_cnt     <= '0;
        r_out.vld <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem[r_wp] <= w_in;
          r_wp        <= r_wp + AW'(1);
        end
        if (w_issue) r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_issue);
        if (w_issue) r_out <= w_out;
        else if (out_ready_i) r_out.vld <= 1'b0;
      end
    end
  end
  assign out_valid_o        = r_out.vld;
  assign operand_alu_a_o    = r_out.alu_a;
  assign operand_alu_b_o    = r_out.alu_b;
  assign operand_pc_alu_a_o = r_out.pc_a;
  assign operand_pc_alu_b_o = r_out.pc_b;
  assign lsu_wdata_o        = r_out.lsu;
  assign operateur_alu_o    = r_out.aop;
  assign req_alu_o          = r_out.alu;
  assign data_req_o         = r_out.dr;
  assign data_we_o          = r_out.dw;
  assign branch_bool_o      = r_out.br;
  assign rf_soursel_o       = r_out.src;
  assign req_rf_w_o         = r_out.rfw;
  assign rf_waddr_o         = r_out.wa;
endmodule
